// File: rtl/bcd_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter: FSM states,
// add-3 constants and the seven-segment decoder used when BCD_SEG_EN is defined.
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [3:0] ADD3_THRESH = 4'd5;
    localparam logic [3:0] ADD3_VAL    = 4'd3;

    function automatic longint unsigned pow10(input int n);
        longint unsigned r;
        r = 1;
        for (int i = 0; i < n; i++) r = r * 10;
        return r;
    endfunction

    // Active-low {dp,g,f,e,d,c,b,a}; non-decimal codes blank the digit.
    function automatic logic [7:0] seg7(input logic [3:0] d);
        logic [7:0] s;
        case (d)
            4'd0:    s = 8'hC0;
            4'd1:    s = 8'hF9;
            4'd2:    s = 8'hA4;
            4'd3:    s = 8'hB0;
            4'd4:    s = 8'h99;
            4'd5:    s = 8'h92;
            4'd6:    s = 8'h82;
            4'd7:    s = 8'hF8;
            4'd8:    s = 8'h80;
            4'd9:    s = 8'h90;
            default: s = 8'hFF;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/bcd_seq_conv_if.sv
// Handshake bundle for bcd_seq_conv. Valid/ready: a transfer happens on a rising
// edge where valid and ready are both high; the producer holds data and valid until then.
interface bcd_seq_conv_if
    import bcd_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
);
    logic                  i_valid;
    logic [WIDTH-1:0]      i_bin;
    logic                  o_ready;
    logic                  o_valid;
    logic [DIGITS*4-1:0]   o_bcd;
    logic                  i_ready;
    logic                  o_busy;
    state_t                o_dbg_state;
`ifdef BCD_SEG_EN
    logic [DIGITS*8-1:0]   o_seg;
`endif

    modport slave (
        input  i_valid, i_bin, i_ready,
        output o_ready, o_valid, o_bcd, o_busy, o_dbg_state
`ifdef BCD_SEG_EN
        , output o_seg
`endif
    );

    modport master (
        output i_valid, i_bin, i_ready,
        input  o_ready, o_valid, o_bcd, o_busy, o_dbg_state
`ifdef BCD_SEG_EN
        , input o_seg
`endif
    );
endinterface

// File: rtl/bcd_dabble_step.sv
// One double-dabble stage: add 3 to every BCD nibble >= 5, then shift the
// whole {bcd, bin} register left by one. Purely combinational.
module bcd_dabble_step
    import bcd_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic [DIGITS*4+WIDTH-1:0] i_reg,
    output logic [DIGITS*4+WIDTH-1:0] o_reg
);
    logic [DIGITS*4+WIDTH-1:0] w_adj;

    always_comb begin
        w_adj = i_reg;
        for (int d = 0; d < DIGITS; d++) begin
            if (i_reg[WIDTH+4*d +: 4] >= ADD3_THRESH)
                w_adj[WIDTH+4*d +: 4] = i_reg[WIDTH+4*d +: 4] + ADD3_VAL;
        end
    end

    assign o_reg = w_adj << 1;
endmodule

// File: rtl/bcd_seq_conv.sv
// Sequential binary-to-BCD converter, one double-dabble step per clock.
// Optional seven-segment output enabled by defining BCD_SEG_EN.
module bcd_seq_conv
    import bcd_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic          i_clk,
    input  logic          i_rst,
    bcd_seq_conv_if.slave bus
);
    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam int REG_W = DIGITS*4 + WIDTH;

    if (WIDTH < 4 || WIDTH > 16) begin : g_bad_width
        $error("bcd_seq_conv: WIDTH must be within 4..16");
    end
    if (pow10(DIGITS) <= (64'd1 << WIDTH) - 64'd1) begin : g_bad_digits
        $error("bcd_seq_conv: DIGITS too small for WIDTH");
    end

    state_t              r_state;
    state_t              w_next_state;
    logic [REG_W-1:0]    r_shreg;
    logic [REG_W-1:0]    w_step;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_valid;
    logic [DIGITS*4-1:0] r_bcd;
    logic                w_accept;
    logic                w_last;

    assign w_accept = (r_state == IDLE) && bus.i_valid;
    assign w_last   = (r_state == SHIFT) && (r_cnt == CNT_W'(WIDTH - 1));

    bcd_dabble_step #(.WIDTH(WIDTH), .DIGITS(DIGITS)) u_step (
        .i_reg (r_shreg),
        .o_reg (w_step)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_state <= IDLE;
        else       r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (bus.i_valid) w_next_state = SHIFT;
            SHIFT:   if (w_last)      w_next_state = DONE;
            DONE:    if (bus.i_ready) w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_shreg <= '0;
            r_cnt   <= '0;
            r_valid <= 1'b0;
            r_bcd   <= '0;
        end else begin
            if (w_accept) begin
                r_shreg <= {{(DIGITS*4){1'b0}}, bus.i_bin};
                r_cnt   <= '0;
            end else if (r_state == SHIFT) begin
                r_shreg <= w_step;
                r_cnt   <= r_cnt + 1'b1;
            end
            if (w_last) begin
                r_bcd   <= w_step[REG_W-1 -: DIGITS*4];
                r_valid <= 1'b1;
            end else if (r_state == DONE && bus.i_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

`ifdef BCD_SEG_EN
    logic [DIGITS*8-1:0] r_seg;
    logic [DIGITS*8-1:0] w_seg;

    always_comb begin
        w_seg = '1;
        for (int d = 0; d < DIGITS; d++)
            w_seg[8*d +: 8] = seg7(w_step[WIDTH+4*d +: 4]);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)       r_seg <= '1;
        else if (w_last) r_seg <= w_seg;
    end

    assign bus.o_seg = r_seg;
`endif

    assign bus.o_ready     = (r_state == IDLE);
    assign bus.o_busy      = (r_state == SHIFT);
    assign bus.o_valid     = r_valid;
    assign bus.o_bcd       = r_bcd;
    assign bus.o_dbg_state = r_state;
endmodule

// File: tb/tb_bcd_seq_conv.sv
// Directed plus randomized bench for bcd_seq_conv (WIDTH 8, DIGITS 3) against
// an arithmetic decimal-digit model.
module tb_bcd_seq_conv;
    import bcd_pkg::*;

    localparam int WIDTH  = 8;
    localparam int DIGITS = 3;
    localparam int BW     = DIGITS*4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    bcd_seq_conv_if #(.WIDTH(WIDTH), .DIGITS(DIGITS)) bus ();

    bcd_seq_conv #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;
    logic [BW-1:0] exp_q[$];
    logic [7:0] seg_tbl[10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

    function automatic logic [BW-1:0] to_bcd(input int v);
        return BW'((((v / 100) % 10) << 8) | (((v / 10) % 10) << 4) | (v % 10));
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_result(input string tag, input logic [BW-1:0] exp);
        check({tag, "_bcd"}, 32'(bus.o_bcd), 32'(exp));
`ifdef BCD_SEG_EN
        check({tag, "_seg"}, 32'(bus.o_seg),
              32'({seg_tbl[exp[11:8]], seg_tbl[exp[7:4]], seg_tbl[exp[3:0]]}));
`endif
    endtask

    task automatic wait_ready();
        int t;
        t = 0;
        while (!bus.o_ready && t < 30) begin
            step();
            t++;
        end
        check("ready_wait", 32'(bus.o_ready), 32'd1);
    endtask

    task automatic wait_valid(output int lat, output int busy);
        lat = 0;
        busy = 0;
        while (!bus.o_valid && lat < 60) begin
            if (bus.o_busy) busy++;
            step();
            lat++;
        end
    endtask

    task automatic run_conv(input int v, input int hold);
        int lat, busy;
        logic [BW-1:0] exp;
        wait_ready();
        bus.i_valid = 1'b1;
        bus.i_bin   = v[WIDTH-1:0];
        exp_q.push_back(to_bcd(v));
        step();
        bus.i_valid = 1'b0;
        bus.i_bin   = WIDTH'($urandom_range(0, 255));
        wait_valid(lat, busy);
        check("latency", 32'(lat), 32'(WIDTH));
        check("busy_cycles", 32'(busy), 32'(WIDTH));
        exp = exp_q.pop_front();
        check_result("conv", exp);
        for (int h = 0; h < hold; h++) begin
            bus.i_ready = 1'b0;
            step();
            check_result("hold", exp);
            check("hold_valid", 32'(bus.o_valid), 32'd1);
            check("hold_ready", 32'(bus.o_ready), 32'd0);
        end
        bus.i_ready = 1'b1;
        step();
        bus.i_ready = 1'b0;
        check("post_hs_valid", 32'(bus.o_valid), 32'd0);
        check("post_hs_ready", 32'(bus.o_ready), 32'd1);
    endtask

    initial begin
        int lat, busy, n_acc, got;
        int acc_t[2];
        bit acc_now, saw_valid;
        logic [BW-1:0] exp;

        bus.i_valid = 1'b0;
        bus.i_bin   = '0;
        bus.i_ready = 1'b0;

        // Reset values
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_ready", 32'(bus.o_ready), 32'd1);
        check("rst_valid", 32'(bus.o_valid), 32'd0);
        check("rst_busy", 32'(bus.o_busy), 32'd0);
        check("rst_bcd", 32'(bus.o_bcd), 32'd0);
        check("rst_state", 32'(bus.o_dbg_state), 32'(IDLE));
`ifdef BCD_SEG_EN
        check("rst_seg", 32'(bus.o_seg), 32'hFFFFFF);
`endif

        // Max value, then a segment-friendly value
        run_conv(255, 0);
        run_conv(42, 1);

        // Back-to-back 0 then 99 with i_ready held; accept spacing
        bus.i_ready = 1'b1;
        bus.i_valid = 1'b1;
        bus.i_bin   = '0;
        n_acc = 0;
        got   = 0;
        for (int s = 0; s < 40 && got < 2; s++) begin
            acc_now = bus.o_ready && bus.i_valid;
            if (bus.o_valid) begin
                exp = exp_q.pop_front();
                check_result("b2b", exp);
                got++;
            end
            if (acc_now) exp_q.push_back(to_bcd(int'(bus.i_bin)));
            step();
            if (acc_now) begin
                acc_t[n_acc] = cyc;
                n_acc++;
                if (n_acc == 1) bus.i_bin = 8'd99;
                else            bus.i_valid = 1'b0;
            end
        end
        check("b2b_results", 32'(got), 32'd2);
        check("b2b_spacing", 32'(acc_t[1] - acc_t[0]), 32'(WIDTH + 2));
        bus.i_ready = 1'b0;
        step();

        // Backpressure with a pending request held on the input
        wait_ready();
        bus.i_valid = 1'b1;
        bus.i_bin   = 8'd128;
        step();
        bus.i_bin = 8'd7;
        wait_valid(lat, busy);
        check("bp_latency", 32'(lat), 32'(WIDTH));
        check_result("bp_conv", to_bcd(128));
        for (int h = 0; h < 6; h++) begin
            step();
            check_result("bp_hold", to_bcd(128));
            check("bp_hold_ready", 32'(bus.o_ready), 32'd0);
            check("bp_hold_state", 32'(bus.o_dbg_state), 32'(DONE));
        end
        bus.i_ready = 1'b1;
        step();
        check("bp_idle_ready", 32'(bus.o_ready), 32'd1);
        check("bp_idle_valid", 32'(bus.o_valid), 32'd0);
        step();
        bus.i_valid = 1'b0;
        bus.i_ready = 1'b0;
        check("bp_accept_busy", 32'(bus.o_busy), 32'd1);
        wait_valid(lat, busy);
        check("bp_second_latency", 32'(lat), 32'(WIDTH));
        check_result("bp_second", to_bcd(7));
        bus.i_ready = 1'b1;
        step();
        bus.i_ready = 1'b0;

        // Reset in the middle of SHIFT
        wait_ready();
        bus.i_valid = 1'b1;
        bus.i_bin   = 8'd200;
        step();
        bus.i_valid = 1'b0;
        repeat (4) step();
        check("mid_busy", 32'(bus.o_busy), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_ready", 32'(bus.o_ready), 32'd1);
        check("mid_rst_busy", 32'(bus.o_busy), 32'd0);
        check("mid_rst_valid", 32'(bus.o_valid), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        saw_valid = 1'b0;
        for (int s = 0; s < 12; s++) begin
            if (bus.o_valid) saw_valid = 1'b1;
            step();
        end
        check("mid_rst_no_valid", 32'(saw_valid), 32'd0);
        run_conv(128, 0);

        // Random values and random output stall lengths
        for (int r = 0; r < 12; r++)
            run_conv(int'($urandom_range(0, 255)), int'($urandom_range(0, 3)));
        run_conv(0, 0);

        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end
endmodule
